// File: rtl/intel_sfifo_fwft.sv
// intel_sfifo_fwft: single-clock FWFT FIFO on an inferred dual-port RAM with a prefetch skid buffer
module intel_sfifo_fwft #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11,
  parameter     BRAM_TYPE  = "M20K",
  parameter int RAM_DO_REG = 0,
  parameter int AFULL_TH   = (1 << ADDR_W) - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              afull,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              aempty,
  output logic [ADDR_W:0]   count,
  output logic              wr_ovf,
  output logic              rd_udf
);
  localparam int CAP = 1 << ADDR_W;
  localparam int L   = 1 + RAM_DO_REG;
  localparam int S   = L + 1;
  localparam int CW  = ADDR_W + 1;
  localparam int SW  = $clog2(S + 1);

  if (RAM_DO_REG > 1 || BRAM_TYPE == "") begin : g_bad_cfg
    $error("intel_sfifo_fwft: unsupported configuration");
  end

  logic [DATA_W-1:0] r_mem [CAP];
  logic [DATA_W-1:0] r_rq, w_rdat;
  logic [DATA_W-1:0] r_skid [S];
  logic [DATA_W-1:0] w_skid [S];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [CW-1:0]     r_count, r_ram_n, w_cnt_nx;
  logic [SW-1:0]     r_skid_n, w_pos;
  logic [L-1:0]      r_vld;
  logic [L:0]        w_vsh;
  logic [1:0]        w_infl;
  logic [3:0]        w_occ;
  logic              w_wr, w_pop, w_iss, w_ret, w_valid;
  logic              r_full, r_afull, r_aempty, r_wovf, r_rudf;

  assign w_valid  = r_skid_n != '0;
  assign w_wr     = wr_en & ~r_full & ~flush;
  assign w_pop    = rd_en & w_valid & ~flush;
  assign w_ret    = r_vld[L-1];
  assign w_vsh    = {r_vld, w_iss};
  assign w_occ    = 4'(r_skid_n) + 4'(w_infl) - 4'(w_pop);
  assign w_iss    = (r_ram_n != '0) && (w_occ < 4'(S));
  assign w_pos    = r_skid_n - SW'(w_pop);
  assign w_cnt_nx = r_count + CW'(w_wr) - CW'(w_pop);

  assign full       = r_full;
  assign afull      = r_afull;
  assign aempty     = r_aempty;
  assign count      = r_count;
  assign wr_ovf     = r_wovf;
  assign rd_udf     = r_rudf;
  assign dout       = r_skid[0];
  assign dout_valid = w_valid;

  // number of RAM reads still travelling through the read pipeline
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < L; i++) w_infl = w_infl + {1'b0, r_vld[i]};
  end

  // skid buffer next state: shift out the head on pop, append the returning RAM word behind the survivors
  always_comb begin
    for (int i = 0; i < S - 1; i++) w_skid[i] = w_pop ? r_skid[i+1] : r_skid[i];
    w_skid[S-1] = w_pop ? '0 : r_skid[S-1];
    if (w_ret) w_skid[w_pos] = w_rdat;
  end

  // RAM array: write port plus first read stage, only reading words written on earlier edges
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
    if (w_iss) r_rq <= r_mem[r_rptr];
  end

  if (RAM_DO_REG != 0) begin : g_do_reg
    logic [DATA_W-1:0] r_rq2;
    // optional RAM output register
    always_ff @(posedge clk) r_rq2 <= r_rq;
    assign w_rdat = r_rq2;
  end else begin : g_no_reg
    assign w_rdat = r_rq;
  end

  // pointers, occupancy, prefetch pipeline, skid buffer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ram_n  <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_skid_n <= '0;
      r_skid   <= '{default: '0};
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_wovf   <= 1'b0;
      r_rudf   <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ram_n  <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_skid_n <= '0;
      r_skid   <= '{default: '0};
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_wovf   <= 1'b0;
      r_rudf   <= 1'b0;
    end else begin
      r_wptr   <= r_wptr + ADDR_W'(w_wr);
      r_rptr   <= r_rptr + ADDR_W'(w_iss);
      r_ram_n  <= r_ram_n + CW'(w_wr) - CW'(w_iss);
      r_count  <= w_cnt_nx;
      r_vld    <= w_vsh[L-1:0];
      r_skid_n <= r_skid_n - SW'(w_pop) + SW'(w_ret);
      r_skid   <= w_skid;
      r_full   <= w_cnt_nx == CW'(CAP);
      r_afull  <= w_cnt_nx >= CW'(AFULL_TH);
      r_aempty <= w_cnt_nx <= CW'(AEMPTY_TH);
      r_wovf   <= wr_en & r_full;
      r_rudf   <= rd_en & ~w_valid;
    end
  end
endmodule

// File: tb/tb_intel_sfifo_fwft.sv
// tb_intel_sfifo_fwft: directed checks of two FIFO instances (unregistered and registered RAM output)
module tb_intel_sfifo_fwft;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       d0_full, d0_afull, d0_valid, d0_aempty, d0_ovf, d0_udf;
  logic       d1_full, d1_afull, d1_valid, d1_aempty, d1_ovf, d1_udf;
  logic [7:0] d0_dout, d1_dout;
  logic [4:0] d0_count, d1_count;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  intel_sfifo_fwft #(.DATA_W(8), .ADDR_W(4), .RAM_DO_REG(0), .AFULL_TH(12), .AEMPTY_TH(2)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(d0_full), .afull(d0_afull), .rd_en(rd_en), .dout(d0_dout), .dout_valid(d0_valid),
    .aempty(d0_aempty), .count(d0_count), .wr_ovf(d0_ovf), .rd_udf(d0_udf));

  intel_sfifo_fwft #(.DATA_W(8), .ADDR_W(4), .RAM_DO_REG(1), .AFULL_TH(12), .AEMPTY_TH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(d1_full), .afull(d1_afull), .rd_en(rd_en), .dout(d1_dout), .dout_valid(d1_valid),
    .aempty(d1_aempty), .count(d1_count), .wr_ovf(d1_ovf), .rd_udf(d1_udf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({d0_dout, d0_valid, d0_full, d0_afull, d0_aempty, d0_ovf, d0_udf, d0_count} !== {8'h00, 6'b000100, 5'd0}) begin
      n_err++; $display("FAIL reset_u0 got %h want %h", {d0_dout, d0_valid, d0_full, d0_afull, d0_aempty, d0_ovf, d0_udf, d0_count}, {8'h00, 6'b000100, 5'd0});
    end
    n_cmp++;
    if ({d1_dout, d1_valid, d1_full, d1_afull, d1_aempty, d1_ovf, d1_udf, d1_count} !== {8'h00, 6'b000100, 5'd0}) begin
      n_err++; $display("FAIL reset_u1 got %h want %h", {d1_dout, d1_valid, d1_full, d1_afull, d1_aempty, d1_ovf, d1_udf, d1_count}, {8'h00, 6'b000100, 5'd0});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if ({d0_count, d1_count, d0_valid, d1_valid} !== {5'd1, 5'd1, 2'b00}) begin
      n_err++; $display("FAIL lat_edgeN got %h want %h", {d0_count, d1_count, d0_valid, d1_valid}, {5'd1, 5'd1, 2'b00});
    end
    step();
    n_cmp++;
    if ({d0_valid, d1_valid} !== 2'b00) begin
      n_err++; $display("FAIL lat_edgeN1 got %b want 00", {d0_valid, d1_valid});
    end
    step();
    n_cmp++;
    if ({d0_valid, d0_dout, d1_valid} !== {1'b1, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL lat_u0_2cyc got %h want %h", {d0_valid, d0_dout, d1_valid}, {1'b1, 8'hA5, 1'b0});
    end
    step();
    n_cmp++;
    if ({d1_valid, d1_dout, d1_count} !== {1'b1, 8'hA5, 5'd1}) begin
      n_err++; $display("FAIL lat_u1_3cyc got %h want %h", {d1_valid, d1_dout, d1_count}, {1'b1, 8'hA5, 5'd1});
    end
  endtask

  task automatic test_fill_drain();
    logic [4:0] c;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      c = 5'(i + 1);
      n_cmp++;
      if ({d0_count, d0_afull, d0_aempty} !== {c, c >= 5'd12, c <= 5'd2}) begin
        n_err++; $display("FAIL fill_%0d got %h want %h", i, {d0_count, d0_afull, d0_aempty}, {c, c >= 5'd12, c <= 5'd2});
      end
    end
    n_cmp++;
    if ({d0_full, d1_full, d1_count} !== {2'b11, 5'd16}) begin
      n_err++; $display("FAIL full_flag got %h want %h", {d0_full, d1_full, d1_count}, {2'b11, 5'd16});
    end
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if ({d0_ovf, d1_ovf, d0_count, d1_count} !== {2'b11, 5'd16, 5'd16}) begin
      n_err++; $display("FAIL wr_ovf got %h want %h", {d0_ovf, d1_ovf, d0_count, d1_count}, {2'b11, 5'd16, 5'd16});
    end
    step();
    n_cmp++;
    if ({d0_ovf, d1_ovf} !== 2'b00) begin
      n_err++; $display("FAIL wr_ovf_clear got %b want 00", {d0_ovf, d1_ovf});
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({d0_valid, d0_dout, d1_valid, d1_dout} !== {1'b1, 8'(i), 1'b1, 8'(i)}) begin
        n_err++; $display("FAIL drain_%0d got %h want %h", i, {d0_valid, d0_dout, d1_valid, d1_dout}, {1'b1, 8'(i), 1'b1, 8'(i)});
      end
      step();
      c = 5'(15 - i);
      n_cmp++;
      if ({d0_count, d0_afull, d0_aempty, d0_full} !== {c, c >= 5'd12, c <= 5'd2, 1'b0}) begin
        n_err++; $display("FAIL drain_flags_%0d got %h want %h", i, {d0_count, d0_afull, d0_aempty, d0_full}, {c, c >= 5'd12, c <= 5'd2, 1'b0});
      end
    end
    n_cmp++;
    if ({d0_valid, d1_valid, d0_udf, d1_count} !== {3'b000, 5'd0}) begin
      n_err++; $display("FAIL empty_after_drain got %h want %h", {d0_valid, d1_valid, d0_udf, d1_count}, {3'b000, 5'd0});
    end
    step();
    rd_en = 1'b0;
    n_cmp++;
    if ({d0_udf, d1_udf, d0_count} !== {2'b11, 5'd0}) begin
      n_err++; $display("FAIL rd_udf got %h want %h", {d0_udf, d1_udf, d0_count}, {2'b11, 5'd0});
    end
    step();
    n_cmp++;
    if ({d0_udf, d1_udf} !== 2'b00) begin
      n_err++; $display("FAIL rd_udf_clear got %b want 00", {d0_udf, d1_udf});
    end
  endtask

  task automatic test_stream();
    logic [7:0] v;
    do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE0 + i); q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 100; i++) begin
      v = 8'($urandom);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = v;
      n_cmp++;
      if ({d0_valid, d0_dout} !== {1'b1, q[0]}) begin
        n_err++; $display("FAIL stream_%0d got %h want %h", i, {d0_valid, d0_dout}, {1'b1, q[0]});
      end
      void'(q.pop_front());
      q.push_back(v);
      step();
      n_cmp++;
      if (d0_count !== 5'd3) begin
        n_err++; $display("FAIL stream_count_%0d got %0d want 3", i, d0_count);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    n_cmp++;
    if ({d0_count, d1_count} !== {5'd5, 5'd5}) begin
      n_err++; $display("FAIL flush_pre got %h want %h", {d0_count, d1_count}, {5'd5, 5'd5});
    end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if ({d0_count, d0_valid, d0_ovf, d0_udf, d0_aempty, d1_count, d1_valid, d1_ovf, d1_udf, d1_aempty} !== {5'd0, 4'b0001, 5'd0, 4'b0001}) begin
      n_err++; $display("FAIL flush_state got %h want %h", {d0_count, d0_valid, d0_ovf, d0_udf, d0_aempty, d1_count, d1_valid, d1_ovf, d1_udf, d1_aempty}, {5'd0, 4'b0001, 5'd0, 4'b0001});
    end
    step();
    n_cmp++;
    if ({d0_valid, d1_valid} !== 2'b00) begin
      n_err++; $display("FAIL flush_no_stale got %b want 00", {d0_valid, d1_valid});
    end
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    step();
    n_cmp++;
    if ({d0_valid, d0_dout, d0_count} !== {1'b1, 8'h3C, 5'd1}) begin
      n_err++; $display("FAIL flush_after_u0 got %h want %h", {d0_valid, d0_dout, d0_count}, {1'b1, 8'h3C, 5'd1});
    end
    step();
    n_cmp++;
    if ({d1_valid, d1_dout, d1_count} !== {1'b1, 8'h3C, 5'd1}) begin
      n_err++; $display("FAIL flush_after_u1 got %h want %h", {d1_valid, d1_dout, d1_count}, {1'b1, 8'h3C, 5'd1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_en = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d0_dout, d0_valid, d0_full, d0_afull, d0_aempty, d0_ovf, d0_udf, d0_count} !== {8'h00, 6'b000100, 5'd0}) begin
      n_err++; $display("FAIL async_rst_u0 got %h want %h", {d0_dout, d0_valid, d0_full, d0_afull, d0_aempty, d0_ovf, d0_udf, d0_count}, {8'h00, 6'b000100, 5'd0});
    end
    n_cmp++;
    if ({d1_dout, d1_valid, d1_full, d1_afull, d1_aempty, d1_ovf, d1_udf, d1_count} !== {8'h00, 6'b000100, 5'd0}) begin
      n_err++; $display("FAIL async_rst_u1 got %h want %h", {d1_dout, d1_valid, d1_full, d1_afull, d1_aempty, d1_ovf, d1_udf, d1_count}, {8'h00, 6'b000100, 5'd0});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({d0_valid, d1_valid, d0_dout, d1_dout, d1_count} !== {2'b00, 16'h0000, 5'd0}) begin
        n_err++; $display("FAIL post_rst_%0d got %h want %h", i, {d0_valid, d1_valid, d0_dout, d1_dout, d1_count}, {2'b00, 16'h0000, 5'd0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_drain();
    test_stream();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/intel_sfifo_fwft.md
Name: intel_sfifo_fwft

Overview:
- Single-clock, first-word-fall-through FIFO built on an inferred simple-dual-port RAM (altsyncram DUAL_PORT, OLD_DATA), generalised over width, depth, RAM block type and RAM output-register latency.
- A small prefetch skid buffer hides the RAM read latency, so the head word is always presented at the output and a pop is possible on every cycle.
- Adds occupancy count, almost-full and almost-empty thresholds, synchronous flush, and overflow/underflow error pulses.
- Intended as the common buffering primitive for DMA descriptor and data paths.

Parameters:
- DATA_W, 8, word width in bits (1..1024).
- ADDR_W, 11, RAM address width. Total capacity CAP = 2**ADDR_W words.
- BRAM_TYPE, "M20K", RAM block type passed to the RAM primitive.
- RAM_DO_REG, 0, 1 = RAM output registered. RAM read latency L = 1 + RAM_DO_REG.
- AFULL_TH, CAP-4, afull asserts when count >= AFULL_TH (1..CAP).
- AEMPTY_TH, 4, aempty asserts when count <= AEMPTY_TH (0..CAP-1).

Ports:
- clk  in  1  single clock for all logic and both RAM ports.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- full  out  1  count == CAP.
- afull  out  1  almost full.
- rd_en  in  1  pop request (acknowledges dout).
- dout  out  DATA_W  head word; valid when dout_valid = 1.
- dout_valid  out  1  head word present (equivalent to not-empty).
- aempty  out  1  almost empty.
- count  out  ADDR_W+1  total words held (RAM + in-flight reads + skid buffer).
- wr_ovf  out  1  one-cycle pulse: wr_en while full.
- rd_udf  out  1  one-cycle pulse: rd_en while !dout_valid.

Behaviour:
- Reset values (rst_n low, asynchronous): pointers, count and skid buffer cleared; dout = 0, dout_valid = 0, full = 0, afull = 0, aempty = 1, wr_ovf = 0, rd_udf = 0.
- All outputs are registered and reflect state after the current edge.
- Write accept: wr_en && !full. Data is written at RAM address wptr and wptr increments modulo CAP. If wr_en && full, the write is dropped, nothing changes, and wr_ovf pulses.
- Pop accept: rd_en && dout_valid. The skid buffer head is removed and the next entry is presented on the following cycle. If rd_en && !dout_valid, nothing changes and rd_udf pulses.
- count: +1 on accepted write only, -1 on accepted pop only, unchanged when both or neither occur. Flags derive from the next count value: full = (count == CAP); afull = (count >= AFULL_TH); aempty = (count <= AEMPTY_TH).
- Full is evaluated on current count. When the FIFO is full, a write is rejected even if a pop occurs in the same cycle.
- Prefetch engine:
  - Skid depth S = L + 1.
  - A RAM read is issued at rptr when ram_words > 0 and (skid_words + inflight − pop_this_cycle) < S. rptr then increments modulo CAP.
  - The returned word enters the skid buffer L cycles after issue. An L-stage valid shift register tracks in-flight reads.
- Read-during-write: a read is issued only for words whose write completed on an earlier edge, so same-address collisions never occur.
- Latency on an empty FIFO: a write accepted at edge N produces dout_valid = 1 after edge N+1+L, i.e. 2 cycles (RAM_DO_REG = 0) or 3 cycles (RAM_DO_REG = 1).
- Throughput: with simultaneous write and pop every cycle in steady state, dout_valid remains 1 and data order is strictly preserved.
- Wrap-around: pointers wrap at CAP with no gap. Full is decided from count, not from pointer compare.
- flush:
  - Has priority over wr_en and rd_en in the same cycle.
  - After the edge: pointers, count, skid buffer and in-flight valids are cleared. dout_valid = 0 and aempty = 1.
  - In-flight RAM returns are discarded.
  - wr_ovf and rd_udf are not raised in the flush cycle.
- Reset asserted mid-operation discards everything immediately. RAM contents are not cleared, but they are unreachable after reset.

Test Plan:
- Reset, then write 0xA5 once (DATA_W = 8, RAM_DO_REG = 0) -> dout_valid = 1 and dout = 0xA5 exactly 2 cycles after the write edge; count = 1. Repeat with RAM_DO_REG = 1 -> 3 cycles.
- Fill with CAP writes of values 0..CAP-1 (ADDR_W = 4, CAP = 16) -> full = 1 and count = 16; a 17th write produces wr_ovf pulse = 1 and count stays 16. Then drain 16 pops -> dout sequence 0..15, dout_valid = 0, and rd_udf pulses on the extra pop.
- Streaming: write and pop every cycle for 100 cycles with a random pattern after 3 prefill words -> no dout_valid gap, count constant at 3, order matches the scoreboard, pointers wrap 6 times.
- Thresholds: AFULL_TH = 12, AEMPTY_TH = 2 -> afull rises on the edge count goes 11→12 and falls on 12→11; aempty falls on 2→3.
- Flush with 5 words held, asserted together with wr_en and rd_en -> next cycle count = 0, dout_valid = 0, no pulses. A subsequent write of 0x3C appears on dout with no stale data.
- Assert rst_n low mid-stream for 1 cycle (RAM_DO_REG = 1, 2 reads in flight) -> all outputs take reset values asynchronously, and the in-flight data never appears on dout.
